sram_port_arbiter: RTL
======================

# sram_port_arbiter

Shares the single external SRAM port between three requesters: port 0 is the UART loader (write-only in practice), and ports 1 and 2 are read/write clients such as the display fetcher and the processing core. Each cycle it grants at most one pending request using round-robin, and it drives registered SRAM address, data and write-enable signals. It returns read data with a fixed latency, tagged to the requesting port. The block sits between the requesters and the top-level SRAM controller pins.

## Interface
- ADDR_W, 18, SRAM word address width
- DATA_W, 16, SRAM word width
- READ_LATENCY, 2, cycles from SRAM_address valid to SRAM_read_data sampled (1..4)
- Clock  in  1  system clock; all logic on rising edge
- Resetn  in  1  asynchronous, active-low reset
- Initialize  in  1  synchronous clear: flushes read pipeline, resets RR pointer
- Hold  in  1  when 1, no grants issued; pending Req are kept waiting
- Req  in  3  Req[i]=1: port i has an access pending
- We_n  in  3  We_n[i]=0: port i access is a write
- Address  in  3*ADDR_W  port i address at [i*ADDR_W +: ADDR_W]
- Write_data  in  3*DATA_W  port i write data at [i*DATA_W +: DATA_W]
- Grant  out  3  one-hot, combinational; Grant[i]=1 means port i access is accepted this cycle
- Read_valid  out  3  one-hot pulse; Read_data belongs to port i
- Read_data  out  DATA_W  registered read return
- SRAM_address  out  ADDR_W  registered
- SRAM_write_data  out  DATA_W  registered
- SRAM_we_n  out  1  registered, active-low write strobe
- SRAM_read_data  in  DATA_W  SRAM output bus

## Operation
- **Handshake:** a requester holds Req, We_n, Address and Write_data stable until it sees Grant. An access is accepted in any cycle where Req[i]=1 and Grant[i]=1. Keeping Req high afterwards requests the next access, so back-to-back grants to one port are legal.
- **Arbitration:** the rotating priority pointer `last` (2 bits, values 0..2) holds the most recently granted port.
  - Search order is last+1, last+2, last+3 (mod 3).
  - The first port with Req set is granted.
  - `last` updates on each grant.
  - Reset value of `last` is 2, so port 0 wins the first contention.
- **Hold or Initialize:** when Hold=1 or Initialize=1, Grant=0.
- **Accepted access in cycle C:** at the end of C, the block registers SRAM_address=Address[i], SRAM_write_data=Write_data[i] and SRAM_we_n=We_n[i].
- **No access in C:** SRAM_we_n=1 in C+1. SRAM_address and SRAM_write_data hold their previous values.
- **Writes:** SRAM_we_n is low for exactly one cycle per write. Consecutive writes keep it low across cycles with changing address.
- **Read pipeline:** a shift register of depth READ_LATENCY+1 carries {valid, port id}.
  - Read_data is registered from SRAM_read_data on the edge where the tag exits the pipeline.
  - Read_valid is asserted in that same cycle.
  - Writes enter the pipeline as invalid.
- **No write bubbles:** no turnaround cycle is inserted between a read and a write.
- **Reset values:** Grant=0, Read_valid=0, Read_data=0, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, pipeline all invalid, `last`=2.
- **Initialize=1:** same clearing as reset, applied synchronously at the next edge.
  - In-flight reads are dropped; Read_valid never fires for them.
  - Initialize has priority over Hold and over any pending Req.
- Out-of-range inputs:
  - More than one bit in Grant is never set.
  - Req bits for which We_n or Address are X have no effect when not granted.

## Timing
- **Grant:** combinational from Req, Hold, Initialize and `last`. There is no registered grant latency: Req at cycle C gives Grant in C if the port wins.
- **SRAM signals:** valid in C+1 for an access accepted in C.
- **Read return:** Read_valid[i] and Read_data are valid in cycle C+2+READ_LATENCY (C+4 at default).
- **Throughput:** one access per cycle, sustained. With all three Req held high, grants rotate 0,1,2,0,… with no idle cycles.
- **Worst-case wait:** a continuously requesting port waits at most 2 cycles between grants when Hold=0.

## Test plan
- **Single write:** reset; Req[0]=1, We_n[0]=0, Address0=0x00005, Data0=0xBEEF at cycle C. Required: Grant[0]=1 in C; SRAM_address=0x00005, SRAM_write_data=0xBEEF, SRAM_we_n=0 in C+1; SRAM_we_n=1 in C+2.
- **Single read:** read from port 2 at 0x3FFFF, SRAM model returning 0x1234 after latency 2. Required: Read_valid=3'b100 and Read_data=0x1234 in C+4; no other Read_valid pulses.
- **Round-robin fairness:** all Req held high for 9 cycles from reset. Required: Grant sequence 0,1,2,0,1,2,0,1,2. Then drop Req[1]; required: the sequence alternates 0,2.
- **Hold:** Req[1]=1 and Hold=1 for 5 cycles. Required: Grant=0 and SRAM_we_n=1 throughout. Release Hold; required: Grant[1] in the same cycle.
- **Initialize mid-read:** back-to-back reads from ports 1 and 2, with Initialize pulsed 1 cycle after the second grant. Required: no Read_valid afterwards, SRAM_we_n=1, and the next contention grants port 0 first.
- **Async reset mid-write stream:** drop Resetn during consecutive port-0 writes. Required: SRAM_we_n=1 and Grant=0 immediately (no clock edge needed); all outputs at their reset values.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Three-port round-robin arbiter for a single external SRAM port.
// Registers the SRAM address/data/strobe and returns read data tagged by port after a fixed latency.
module sram_port_arbiter #(
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  Initialize,
   input  logic                  Hold,
   input  logic [2:0]            Req,
   input  logic [2:0]            We_n,
   input  logic [3*ADDR_W-1:0]   Address,
   input  logic [3*DATA_W-1:0]   Write_data,
   output logic [2:0]            Grant,
   output logic [2:0]            Read_valid,
   output logic [DATA_W-1:0]     Read_data,
   output logic [ADDR_W-1:0]     SRAM_address,
   output logic [DATA_W-1:0]     SRAM_write_data,
   output logic                  SRAM_we_n,
   input  logic [DATA_W-1:0]     SRAM_read_data
);

   logic [1:0]                   r_last;
   logic [READ_LATENCY:0]        r_pipe_vld;
   logic [READ_LATENCY:0][1:0]   r_pipe_port;

   logic                         w_gnt_any;
   logic [1:0]                   w_gnt_idx;
   logic [1:0]                   w_cand;
   logic                         w_is_read;
   logic [ADDR_W-1:0]            w_addr_sel;
   logic [DATA_W-1:0]            w_data_sel;

   function automatic logic [1:0] next_port(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Search last+1, last+2, last+3 (mod 3); the first requester found wins.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      Grant     = 3'b000;
      w_gnt_any = 1'b0;
      w_gnt_idx = 2'd0;
      w_cand    = r_last;
      if (Resetn && !Hold && !Initialize) begin
         for (int k = 0; k < 3; k++) begin
            w_cand = next_port(w_cand);
            if (!w_gnt_any && Req[w_cand]) begin
               w_gnt_any = 1'b1;
               w_gnt_idx = w_cand;
            end
         end
         Grant[w_gnt_idx] = w_gnt_any;
      end
   end

   // Only the granted port's controls are looked at, so X on idle ports is harmless.
   assign w_is_read  = w_gnt_any && We_n[w_gnt_idx];
   assign w_addr_sel = Address[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
   assign w_data_sel = Write_data[int'(w_gnt_idx)*DATA_W +: DATA_W];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_last          <= 2'd2;
         // NOTE: the tag pipeline is reset too, so no stale tag can fire Read_valid after reset.
         r_pipe_vld      <= '0;
         r_pipe_port     <= '0;
         Read_valid      <= 3'b000;
         Read_data       <= '0;
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         SRAM_we_n       <= 1'b1;
      end else if (Initialize) begin
         r_last          <= 2'd2;
         r_pipe_vld      <= '0;
         r_pipe_port     <= '0;
         Read_valid      <= 3'b000;
         Read_data       <= '0;
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         SRAM_we_n       <= 1'b1;
      end else begin
         if (w_gnt_any) begin
            r_last          <= w_gnt_idx;
            SRAM_address    <= w_addr_sel;
            SRAM_write_data <= w_data_sel;
            SRAM_we_n       <= We_n[w_gnt_idx];
         end else begin
            SRAM_we_n       <= 1'b1;
         end

         // Writes enter as invalid slots; the last stage times the Read_data capture.
         r_pipe_vld  <= {r_pipe_vld[READ_LATENCY-1:0], w_is_read};
         r_pipe_port <= {r_pipe_port[READ_LATENCY-1:0], w_gnt_idx};

         Read_valid <= r_pipe_vld[READ_LATENCY] ? (3'b001 << r_pipe_port[READ_LATENCY]) : 3'b000;
         if (r_pipe_vld[READ_LATENCY])
            Read_data <= SRAM_read_data;
      end
   end

endmodule
